// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and segment decode for the multiplexed 7-segment driver
package seven_seg_pkg;

    localparam logic [6:0]  SEG_BLANK  = 7'b000_0000;
    localparam logic [31:0] DIGITS_OFF = 32'hFFFF_FFFF;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_segments(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b011_1111;
            4'h1: seg = 7'b000_0110;
            4'h2: seg = 7'b101_1011;
            4'h3: seg = 7'b100_1111;
            4'h4: seg = 7'b110_0110;
            4'h5: seg = 7'b110_1101;
            4'h6: seg = 7'b111_1101;
            4'h7: seg = 7'b000_0111;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b110_1111;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b111_1100;
            4'hC: seg = 7'b011_1001;
            4'hD: seg = 7'b101_1110;
            4'hE: seg = 7'b111_1001;
            default: seg = 7'b111_0001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/multiplex_7seg_display_if.sv
// rtl/multiplex_7seg_display_if.sv - display register inputs and extension-port pin outputs
interface multiplex_7seg_display_if #(
    parameter int NUM_DIGITS = 16
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   decimal_points;
    logic [NUM_DIGITS-1:0]   show_only_these;
    logic [3:0]              brightness;
    logic                    suppress_lz;
    logic [7:0]              extseg_out;
    logic [NUM_DIGITS-1:0]   extdigit_out;
    logic                    frame_start;

    modport master (
        output digits, decimal_points, show_only_these, brightness, suppress_lz,
        input  extseg_out, extdigit_out, frame_start
    );

    modport slave (
        input  digits, decimal_points, show_only_these, brightness, suppress_lz,
        output extseg_out, extdigit_out, frame_start
    );
endinterface

// File: rtl/display_slot_timer.sv
// rtl/display_slot_timer.sv - slot counter, digit index, PWM subinterval and snapshot strobe
module display_slot_timer #(
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 64,
    parameter int NUM_DIGITS   = 16,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic             in_blank,
    output logic [3:0]       sub,
    output logic [IDX_W-1:0] idx,
    output logic             snapshot
);
    localparam int CNT_W   = $clog2(PRESCALE);
    localparam int SUB_LEN = (PRESCALE - BLANK_CYCLES) / 16;
    localparam int FRAC_W  = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        sub_q, sub_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              wrap;

    // sub is tracked incrementally alongside cnt so no divider is needed.
    always_comb begin
        wrap   = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        sub_d  = sub_q;
        frac_d = frac_q;
        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (wrap || (cnt_q < CNT_W'(BLANK_CYCLES))) begin
            sub_d  = '0;
            frac_d = '0;
        end else if (frac_q == FRAC_W'(SUB_LEN - 1)) begin
            frac_d = '0;
            sub_d  = sub_q + 4'd1;
        end else begin
            frac_d = frac_q + FRAC_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            sub_q  <= '0;
            frac_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sub_q  <= sub_d;
            frac_q <= frac_d;
        end
    end

    assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
    assign sub      = sub_q;
    assign idx      = idx_q;
    assign snapshot = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/multiplex_7seg_display.sv
// rtl/multiplex_7seg_display.sv - frame-coherent multiplexed 7-segment driver with PWM and zero blanking
module multiplex_7seg_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 16,
    parameter int DIGIT_BITS   = 4,
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 64,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    multiplex_7seg_display_if.slave  disp
);
    localparam logic [3:0] DIGIT_MASK = (DIGIT_BITS == 3) ? 4'h7 : 4'hF;

    logic             in_blank;
    logic [3:0]       sub;
    logic [IDX_W-1:0] idx;
    logic             snapshot;

    display_slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES),
        .NUM_DIGITS   (NUM_DIGITS)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .in_blank (in_blank),
        .sub      (sub),
        .idx      (idx),
        .snapshot (snapshot)
    );

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   show_q, show_d;
    logic [3:0]              bright_q, bright_d;
    logic                    slz_q, slz_d;

    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    fs_q, fs_d;

    logic [NUM_DIGITS-1:0]   is_zero, zero_from, suppress;
    logic [3:0]              cur_digit;
    logic                    drive;

    // The snapshot cycle decodes from the values being latched so the first slot of a frame is coherent.
    always_comb begin
        digits_d = snapshot ? disp.digits          : digits_q;
        dp_d     = snapshot ? disp.decimal_points  : dp_q;
        show_d   = snapshot ? disp.show_only_these : show_q;
        bright_d = snapshot ? disp.brightness      : bright_q;
        slz_d    = snapshot ? disp.suppress_lz     : slz_q;
    end

    always_comb begin
        is_zero   = '0;
        zero_from = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            is_zero[i] = ((digits_d[4*i +: 4] & DIGIT_MASK) == 4'h0);
        end
        zero_from[NUM_DIGITS-1] = is_zero[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = is_zero[i] & zero_from[i+1];
        end
        suppress = slz_d ? {zero_from[NUM_DIGITS-1:1], 1'b0} : '0;
    end

    always_comb begin
        cur_digit = digits_d[{idx, 2'b00} +: 4] & DIGIT_MASK;
        drive     = !in_blank && (sub <= bright_d) && show_d[idx];
        seg_d     = {1'b0, SEG_BLANK};
        dig_d     = DIGITS_OFF[NUM_DIGITS-1:0];
        fs_d      = snapshot;
        if (drive) begin
            seg_d = {dp_d[idx], suppress[idx] ? SEG_BLANK : hex_to_segments(cur_digit)};
            dig_d = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            digits_q <= '0;
            dp_q     <= '0;
            show_q   <= '0;
            bright_q <= '0;
            slz_q    <= 1'b0;
            seg_q    <= '0;
            dig_q    <= DIGITS_OFF[NUM_DIGITS-1:0];
            fs_q     <= 1'b0;
        end else begin
            digits_q <= digits_d;
            dp_q     <= dp_d;
            show_q   <= show_d;
            bright_q <= bright_d;
            slz_q    <= slz_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            fs_q     <= fs_d;
        end
    end

    assign disp.extseg_out   = seg_q;
    assign disp.extdigit_out = dig_q;
    assign disp.frame_start  = fs_q;

endmodule
